// File: rtl/io_core_byte_rx_fifo.sv
// io_core_byte_rx_fifo: turns the host's toggle-per-byte probe protocol into a buffered FWFT valid/ready byte stream.
// Optional IO_BYTE_RX_DROP_EN: drop-and-ack when full, with sticky overflow and frame state in the status word.
module io_core_byte_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] core_byte_i,
  input  logic       core_toggle_i,
  input  logic       core_last_i,
  output logic [7:0] core_occ_o,
  output logic       core_ack_o,
  output logic       core_space_o,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       m_valid,
  input  logic       m_ready
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [8:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             pending;
  logic             not_full;
  logic             push;
  logic             pop;
  logic             load;
  logic             accept;

  assign pending  = (core_toggle_i != core_ack_o);
  assign not_full = (count < DEPTH_C);
  assign push     = pending && not_full;
  assign pop      = m_valid && m_ready;
  // count includes the byte held in the output stage, so RAM holds bytes only when count exceeds m_valid
  assign load     = (count > CNT_W'(m_valid)) && (!m_valid || m_ready);

`ifdef IO_BYTE_RX_DROP_EN
  assign accept = pending;
`else
  assign accept = push;
`endif

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (!push && pop)
      count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {core_last_i, core_byte_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      count        <= '0;
      core_ack_o   <= 1'b0;
      core_space_o <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (accept)
        core_ack_o <= core_toggle_i;
      count        <= count_next;
      core_space_o <= (count_next < DEPTH_C);
    end
  end

  // Output stage only reloads when empty or being consumed, keeping data stable under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_last  <= 1'b0;
    end else if (load) begin
      {m_last, m_data} <= mem[rd_ptr];
      m_valid          <= 1'b1;
      rd_ptr           <= rd_ptr + PTR_W'(1);
    end else if (pop) begin
      m_valid <= 1'b0;
    end
  end

`ifdef IO_BYTE_RX_DROP_EN
  typedef enum logic {IDLE, IN_FRAME} frame_t;

  frame_t state_reg;
  frame_t state_next;
  logic   in_frame;
  logic   overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      overflow  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (pending && !not_full)
        overflow <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_frame   = (state_reg == IN_FRAME);
    if (push)
      state_next = core_last_i ? IDLE : IN_FRAME;
  end

  assign core_occ_o = {overflow, in_frame, 6'(count)};
`else
  if (CNT_W > 8) begin : g_occ_sat
    assign core_occ_o = (count > CNT_W'(255)) ? 8'hFF : count[7:0];
  end else begin : g_occ_ext
    assign core_occ_o = 8'(count);
  end
`endif

endmodule

// File: tb/tb_io_core_byte_rx_fifo.sv
// Directed bench for io_core_byte_rx_fifo: vector table for the basic handshake plus sequences for full, streaming and reset.
module tb_io_core_byte_rx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] core_byte_i = 8'h00;
  logic       core_toggle_i = 1'b0;
  logic       core_last_i = 1'b0;
  logic [7:0] core_occ_o;
  logic       core_ack_o;
  logic       core_space_o;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready = 1'b0;

  always #5 clk = ~clk;

  io_core_byte_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_byte_i  (core_byte_i),
    .core_toggle_i(core_toggle_i),
    .core_last_i  (core_last_i),
    .core_occ_o   (core_occ_o),
    .core_ack_o   (core_ack_o),
    .core_space_o (core_space_o),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rxq[$];

  typedef struct {
    logic       tgl;
    logic [7:0] b;
    logic       lst;
    logic       rdy;
    logic       ack;
    logic       space;
    int         cnt;
    int         frame;
    logic       vld;
    logic [7:0] d;
    logic       dl;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic int exp_occ(input int cnt, input int frame, input int ovf);
`ifdef IO_BYTE_RX_DROP_EN
    return (ovf << 7) | (frame << 6) | cnt;
`else
    return cnt + 0 * (frame + ovf);
`endif
  endfunction

  function automatic int cnt_of(input logic [7:0] occ);
`ifdef IO_BYTE_RX_DROP_EN
    return int'(occ & 8'h3F);
`else
    return int'(occ);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_push(input logic [7:0] b, input logic l, input int budget, output logic acked);
    core_byte_i   = b;
    core_last_i   = l;
    core_toggle_i = ~core_toggle_i;
    acked = 1'b0;
    for (int k = 0; k < budget && !acked; k++) begin
      step();
      if (core_ack_o == core_toggle_i)
        acked = 1'b1;
    end
  endtask

  task automatic drain(input int cycles);
    rxq.delete();
    m_ready = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      if (m_valid)
        rxq.push_back(m_data);
      step();
    end
    m_ready = 1'b0;
  endtask

  initial begin
    logic ok;
    int   idx;
    int   max_cnt;

    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b1, 8'hA5, 1'b0};
    vecs[3]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b1, 8'hA5, 1'b0};
    vecs[4]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1, 1'b1, 8'h11, 1'b0};
    vecs[7]  = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 1'b1, 8'h11, 1'b0};
    vecs[8]  = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 1'b1, 8'h11, 1'b0};
    vecs[9]  = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 2, 0, 1'b1, 8'h22, 1'b0};
    vecs[10] = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 8'h33, 1'b1};
    vecs[11] = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 8'h00, 1'b0};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst m_valid", int'(m_valid), 0);
    check("rst m_data", int'(m_data), 0);
    check("rst m_last", int'(m_last), 0);
    check("rst ack", int'(core_ack_o), 0);
    check("rst space", int'(core_space_o), 1);
    check("rst occ", int'(core_occ_o), 0);
    step();

    // Single byte, then 3-byte frame with stall and release
    for (int i = 0; i < 13; i++) begin
      core_toggle_i = vecs[i].tgl;
      core_byte_i   = vecs[i].b;
      core_last_i   = vecs[i].lst;
      m_ready       = vecs[i].rdy;
      step();
      check($sformatf("v%0d ack", i), int'(core_ack_o), int'(vecs[i].ack));
      check($sformatf("v%0d space", i), int'(core_space_o), int'(vecs[i].space));
      check($sformatf("v%0d occ", i), int'(core_occ_o), exp_occ(vecs[i].cnt, vecs[i].frame, 0));
      check($sformatf("v%0d m_valid", i), int'(m_valid), int'(vecs[i].vld));
      if (vecs[i].vld) begin
        check($sformatf("v%0d m_data", i), int'(m_data), int'(vecs[i].d));
        check($sformatf("v%0d m_last", i), int'(m_last), int'(vecs[i].dl));
      end
    end

    // Full-rate streaming: 40 bytes, pointers wrap twice
    m_ready = 1'b1;
    core_last_i = 1'b0;
    rxq.delete();
    idx = 0;
    max_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (m_valid)
        rxq.push_back(m_data);
      if (cnt_of(core_occ_o) > max_cnt)
        max_cnt = cnt_of(core_occ_o);
      if (idx < 40 && core_ack_o == core_toggle_i) begin
        core_byte_i   = 8'(idx * 5 + 1);
        core_toggle_i = ~core_toggle_i;
        idx++;
      end
      step();
    end
    m_ready = 1'b0;
    check("stream sent", idx, 40);
    check("stream received", rxq.size(), 40);
    check("stream max occ", int'(max_cnt <= 2), 1);
    for (int i = 0; i < 40 && i < rxq.size(); i++)
      check($sformatf("stream byte %0d", i), int'(rxq[i]), (i * 5 + 1) & 8'hFF);

`ifdef IO_BYTE_RX_DROP_EN
    // Overflow drops the byte but still acks
    for (int i = 0; i < DEPTH; i++) begin
      host_push(8'(8'h70 + i), 1'b0, 3, ok);
      check($sformatf("fill ack %0d", i), int'(ok), 1);
    end
    check("full space", int'(core_space_o), 0);
    check("full occ", int'(core_occ_o), exp_occ(16, 1, 0));
    host_push(8'hEE, 1'b0, 3, ok);
    check("drop acked", int'(ok), 1);
    check("drop occ", int'(core_occ_o), exp_occ(16, 1, 1));
    drain(30);
    check("drop drained", rxq.size(), 16);
    for (int i = 0; i < 16 && i < rxq.size(); i++)
      check($sformatf("drop byte %0d", i), int'(rxq[i]), 8'h70 + i);
`else
    // Backpressure: 17th byte waits for space
    for (int i = 0; i < DEPTH; i++) begin
      host_push(8'(8'h40 + i), 1'b0, 3, ok);
      check($sformatf("fill ack %0d", i), int'(ok), 1);
    end
    check("full space", int'(core_space_o), 0);
    check("full occ", int'(core_occ_o), 16);
    core_byte_i   = 8'h99;
    core_toggle_i = ~core_toggle_i;
    repeat (4) step();
    check("17th held", int'(core_ack_o == core_toggle_i), 0);
    check("head byte", int'(m_data), 8'h40);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 2 && !ok; k++) begin
      step();
      if (core_ack_o == core_toggle_i)
        ok = 1'b1;
    end
    check("17th acked", int'(ok), 1);
    drain(30);
    check("full drained", rxq.size(), 16);
    for (int i = 0; i < 16 && i < rxq.size(); i++)
      check($sformatf("full byte %0d", i), int'(rxq[i]), (i < 15) ? 8'h41 + i : 8'h99);
`endif

    // Reset mid-frame with 5 bytes buffered
    for (int i = 0; i < 5; i++) begin
      host_push(8'(8'h60 + i), 1'b0, 3, ok);
      check($sformatf("pre-rst ack %0d", i), int'(ok), 1);
    end
    step();
    check("pre-rst occ", cnt_of(core_occ_o), 5);
    #2;
    rst = 1'b1;
    core_toggle_i = 1'b1;
    core_byte_i   = 8'h5C;
    core_last_i   = 1'b1;
    #1;
    check("async rst m_valid", int'(m_valid), 0);
    check("async rst occ", int'(core_occ_o), 0);
    check("async rst ack", int'(core_ack_o), 0);
    check("async rst space", int'(core_space_o), 1);
    check("async rst m_data", int'(m_data), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post-rst ack", int'(core_ack_o), 1);
    check("post-rst occ", int'(core_occ_o), exp_occ(1, 0, 0));
    check("post-rst m_valid early", int'(m_valid), 0);
    step();
    check("post-rst m_valid", int'(m_valid), 1);
    check("post-rst m_data", int'(m_data), 8'h5C);
    check("post-rst m_last", int'(m_last), 1);
    m_ready = 1'b1;
    step();
    check("post-rst popped", int'(m_valid), 0);
    check("post-rst empty", int'(core_occ_o), 0);
    repeat (3) step();
    check("no stale bytes", int'(m_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
